bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
- REQ-001: Parameter ADDR_WIDTH, default 9, sets BRAM read-port address width.
- REQ-002: Parameter DATA_WIDTH, default 32, sets the BRAM word and stream data width.
- REQ-003: clk  input  1  sole clock; also drives the BRAM read-port clock.
- REQ-004: reset_n  input  1  reset, asynchronous assert, active-low.
- REQ-005: start  input  1  one-cycle request to begin a burst read.
- REQ-006: base_addr  input  ADDR_WIDTH  first word address, sampled when start is accepted.
- REQ-007: length  input  ADDR_WIDTH+1  word count, sampled with start; 0 means no transfer.
- REQ-008: busy  output  1  high from accepted start until the done pulse, inclusive.
- REQ-009: done  output  1  one-cycle pulse when a burst completes.
- REQ-010: rd_en  output  1  BRAM read-port enable.
- REQ-011: rd_addr  output  ADDR_WIDTH  BRAM read-port address.
- REQ-012: rd_data  input  DATA_WIDTH  BRAM read data, valid the cycle after rd_en.
- REQ-013: m_valid  output  1  stream word valid.
- REQ-014: m_ready  input  1  stream consumer ready.
- REQ-015: m_data  output  DATA_WIDTH  stream word.
- REQ-016: m_last  output  1  marks the final word of the burst, qualified by m_valid.

Function
- REQ-017: FSM states are IDLE, RUN and DONE.
  - IDLE->RUN on start with length!=0.
  - IDLE->DONE on start with length==0.
  - RUN->DONE on the handshake (m_valid&&m_ready) of the word with m_last=1.
  - DONE->IDLE unconditionally after one cycle.
- REQ-018: done=1 only in DONE; busy=1 in RUN and DONE.
- REQ-019: start is ignored when the FSM is not in IDLE.
- REQ-020: The block holds an issue counter (words left to request) and an emit counter (words left to deliver), both loaded with length on accept.
- REQ-021: The first rd_en occurs the cycle after start is accepted, with rd_addr=base_addr.
- REQ-022: Each subsequent read uses the previous address plus 1, modulo 2^ADDR_WIDTH (0x1FF wraps to 0x000 at the default width).
- REQ-023: Read data is captured from rd_data into a 2-entry FIFO at the end of the cycle following rd_en.
- REQ-024: m_valid/m_data reflect the FIFO head, so a word is visible at the earliest 2 cycles after its rd_en.
- REQ-025: Issue rule: rd_en=1 only when all three hold:
  - state RUN;
  - issue counter != 0;
  - (FIFO occupancy - pop_this_cycle + pending) < 2, where pending = rd_en of the previous cycle.
  The FIFO therefore never overflows.
- REQ-026: With m_ready held high, the block sustains one word per cycle after the 2-cycle initial latency.
- REQ-027: While m_valid=1 and m_ready=0, m_data and m_last hold stable.
- REQ-028: Words are delivered in address order with no loss or duplication.
- REQ-029: m_last=1 exactly when the head word is the final one (emit counter == 1).
- REQ-030: When rd_en=0, rd_addr holds its last value.

Reset
- REQ-031: While reset_n=0, the block enters IDLE asynchronously, counters and FIFO are cleared, and all outputs read 0 (busy, done, rd_en, rd_addr, m_valid, m_data, m_last).
- REQ-032: A reset asserted mid-burst abandons it: no done pulse and no further stream words until a new start.
- REQ-033: rd_data returned for a read issued before the reset is discarded.
- REQ-034: The first start is accepted on the first rising edge after reset_n deasserts.

Verification
- REQ-035: BRAM preloaded MEM[i]=i; base=0x010, length=4, m_ready=1.
  - rd_en at cycles 1-4 (start at cycle 0).
  - m_data=0x10,0x11,0x12,0x13 on cycles 3-6, m_last on cycle 6.
  - done on cycle 7.
- REQ-036: base=0x1FE, length=4 -> rd_addr sequence 0x1FE,0x1FF,0x000,0x001; stream values match.
- REQ-037: length=8 with m_ready=0 for cycles 3-9.
  - At most 2 reads are outstanding or buffered.
  - m_data stays at the first word.
  - After release, all 8 words arrive in order.
- REQ-038: length=0 -> done=1 on cycle 1, busy=1 only on cycle 1, rd_en and m_valid never asserted.
- REQ-039: start pulsed again during RUN with different base/length -> ignored; the original burst completes unchanged.
- REQ-040: reset_n pulsed low after 2 of 6 words delivered.
  - All outputs are 0 immediately.
  - No done pulse follows.
  - A new start with base=0x000, length=2 then delivers MEM[0],MEM[1] correctly.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Burst reader: issues sequential BRAM reads and streams the returned words
// through a 2-entry FIFO with valid/ready handshaking.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | issuing reads and streaming words
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   issue_cnt, emit_cnt;
  logic [ADDR_WIDTH-1:0] next_addr, last_addr;
  logic                  pending;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            occ;
  logic                  accept, pop;
  logic [2:0]            room_chk;

  assign accept   = (state == IDLE) && start;
  assign m_valid  = (occ != 2'd0);
  assign pop      = m_valid && m_ready;
  assign m_data   = m_valid ? fifo_mem[rd_ptr] : '0;
  assign m_last   = m_valid && (emit_cnt == CNT_ONE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Words buffered plus the read in flight, after this cycle's pop, must leave room.
  assign room_chk = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
  assign rd_en    = (state == RUN) && (issue_cnt != '0) && (room_chk < 3'd2);
  assign rd_addr  = rd_en ? next_addr : last_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (length == '0) ? DONE : RUN;
      RUN:     if (pop && m_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_cnt <= '0;
      emit_cnt  <= '0;
      next_addr <= '0;
      last_addr <= '0;
      pending   <= 1'b0;
    end else begin
      pending <= rd_en;
      if (accept) begin
        issue_cnt <= length;
        emit_cnt  <= length;
        next_addr <= base_addr;
      end else begin
        if (rd_en) begin
          issue_cnt <= issue_cnt - CNT_ONE;
          next_addr <= next_addr + ADDR_ONE;
          last_addr <= next_addr;
        end
        if (pop) emit_cnt <= emit_cnt - CNT_ONE;
      end
    end
  end

  // Returned data is pushed only for reads issued since the last reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
    end else begin
      if (pending) begin
        fifo_mem[wr_ptr] <= rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, pending} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: burst-level reference model checked every
// cycle, directed scenarios with literal expectations, then random bursts.
module tb_bram_stream_reader;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, rd_en, m_valid, m_ready, m_last;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, m_data;

  logic [DW-1:0] mem [1 << AW];

  int n_checks = 0;
  int n_err    = 0;

  bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // Synchronous-read BRAM: data valid the cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l);
    start = 1'b1; base_addr = b; length = l;
    tick();
    start = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  bit            mdl_busy, mdl_done, first_due, hold_prev;
  logic [AW-1:0] last_addr_m;
  int            issued, popped;

  always @(negedge clk) begin
    bit last_pop;
    last_pop = 0;
    if (!reset_n) begin
      chk("reset_outputs", {busy, done, rd_en, m_valid, m_last, rd_addr, m_data}, 64'd0);
      exp_q.delete(); addr_q.delete();
      mdl_busy = 0; mdl_done = 0; first_due = 0; hold_prev = 0;
      last_addr_m = '0; issued = 0; popped = 0;
    end else begin
      chk("busy", busy, mdl_busy);
      chk("done", done, mdl_done);
      if (first_due) chk("first_rd_en", rd_en, 1);
      first_due = 0;
      if (rd_en) begin
        if (addr_q.size() == 0) fail("rd_en_unexpected");
        else chk("rd_addr", rd_addr, addr_q.pop_front());
        last_addr_m = rd_addr;
        issued++;
      end else begin
        chk("rd_addr_hold", rd_addr, last_addr_m);
      end
      if (hold_prev) chk("stall_valid_hold", m_valid, 1);
      if (m_valid) begin
        if (exp_q.size() == 0) fail("m_valid_unexpected");
        else begin
          chk("m_data", m_data, exp_q[0]);
          chk("m_last", m_last, exp_q.size() == 1);
        end
      end
      hold_prev = m_valid && !m_ready;
      if (m_valid && m_ready && exp_q.size() > 0) begin
        last_pop = (exp_q.size() == 1);
        void'(exp_q.pop_front());
        popped++;
      end
      chk("outstanding_le_2", (issued - popped) <= 2, 1);
      if (mdl_done) begin
        mdl_busy = 0; mdl_done = 0;
      end else if (mdl_busy && last_pop) begin
        mdl_done = 1;
      end else if (!mdl_busy && start) begin
        mdl_busy = 1;
        mdl_done = (length == 0);
        first_due = (length != 0);
        issued = 0; popped = 0;
        for (int i = 0; i < int'(length); i++) begin
          logic [AW-1:0] a;
          a = base_addr + AW'(i);
          addr_q.push_back(a);
          exp_q.push_back(mem[a]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] got_d[$];
  logic [AW-1:0] got_a[$];
  logic [AW-1:0] ea [4];
  bit seen;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = i;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    tick(); tick();
    chk("reset_literal", {busy, done, rd_en, m_valid, m_last, rd_addr, m_data}, 64'd0);
    reset_n = 1'b1;
    m_ready = 1'b1;
    tick();

    // Basic burst: literal timeline
    start_burst(9'h010, 4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("t1_rd_en", rd_en, c <= 4);
      chk("t1_valid", m_valid, c >= 3 && c <= 6);
      if (c >= 3 && c <= 6) chk("t1_data", m_data, 32'h10 + c - 3);
      chk("t1_last", m_last, c == 6);
      chk("t1_done", done, c == 7);
      chk("t1_busy", busy, 1);
      tick();
    end

    // Address wrap
    ea = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
    got_a.delete(); got_d.delete();
    start_burst(9'h1FE, 4);
    seen = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (rd_en) got_a.push_back(rd_addr);
      if (m_valid && m_ready) got_d.push_back(m_data);
      if (done) seen = 1;
      tick();
    end
    chk("t2_done_seen", seen, 1);
    chk("t2_nreads", got_a.size(), 4);
    chk("t2_nwords", got_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_a.size()) chk("t2_addr", got_a[i], ea[i]);
      if (i < got_d.size()) chk("t2_data", got_d[i], {23'd0, ea[i]});
    end

    // Backpressure for cycles 3-9
    got_d.delete();
    start_burst(9'h020, 8);
    seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      m_ready = !(c >= 3 && c <= 9);
      @(negedge clk);
      if (c >= 3 && c <= 9) chk("t3_hold_data", m_data, 32'h20);
      if (m_valid && m_ready) got_d.push_back(m_data);
      if (done) seen = 1;
      tick();
    end
    m_ready = 1'b1;
    chk("t3_done_seen", seen, 1);
    chk("t3_nwords", got_d.size(), 8);
    foreach (got_d[i]) chk("t3_order", got_d[i], 32'h20 + i);

    // Zero length
    start_burst(9'h055, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("t4_busy", busy, c == 1);
      chk("t4_done", done, c == 1);
      chk("t4_rd_en", rd_en, 0);
      chk("t4_valid", m_valid, 0);
      tick();
    end

    // Start during RUN is ignored
    got_d.delete();
    start_burst(9'h080, 5);
    seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (c == 2) begin start = 1'b1; base_addr = 9'h100; length = 3; end
      else start = 1'b0;
      @(negedge clk);
      if (m_valid && m_ready) got_d.push_back(m_data);
      if (done) seen = 1;
      tick();
    end
    start = 1'b0;
    chk("t5_done_seen", seen, 1);
    chk("t5_nwords", got_d.size(), 5);
    foreach (got_d[i]) chk("t5_data", got_d[i], 32'h80 + i);
    @(negedge clk);
    chk("t5_idle_after", busy, 0);
    tick();

    // Reset mid-burst after 2 words
    start_burst(9'h040, 6);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tick();
    end
    reset_n = 1'b0;
    #1;
    chk("t6_outs_zero", {busy, done, rd_en, m_valid, m_last, rd_addr, m_data}, 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    start_burst(9'h000, 2);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("t6_valid", m_valid, c == 3 || c == 4);
      if (c == 3 || c == 4) chk("t6_data", m_data, c - 3);
      chk("t6_done", done, c == 5);
      tick();
    end

    // Random bursts against the model
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    for (int b = 0; b < 40; b++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      start_burst(AW'($urandom_range(0, 511)),
                  ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 20)));
      seen = 0;
      for (int c = 0; c < 600 && !seen; c++) begin
        @(negedge clk);
        if (done) seen = 1;
        else begin
          tick();
          m_ready   = ($urandom_range(0, 3) != 0);
          start     = ($urandom_range(0, 15) == 0);
          base_addr = AW'($urandom);
          length    = 10'($urandom);
        end
      end
      if (!seen) fail("rand_timeout");
      tick();
      start = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
